// File: rtl/scan_frame_tx.sv
`timescale 1ns/1ps
// scan_frame_tx
//   Session sequencer for a scan sink: ARM (select only), LOAD (preamble on
//   l_in for pre_len+1 cycles), MARK (one cycle), then RUN where completed
//   frames are counted while the sink's address is cross-checked against a
//   locally decrementing shadow address. TEARDOWN pulses done for one cycle.
//
// Ports
//   clock       rising-edge clock
//   reset       synchronous, active-high reset
//   start       session request, sampled only in IDLE
//   stop        abort request, honoured in ARM/LOAD/MARK/RUN
//   pre_len     extra preamble cycles, latched with start
//   num_frames  frames per session (0 = unlimited), latched with start
//   fz_L        frame-active flag from the sink
//   read_a      sink address, checked in RUN
//   s, dv, l_in select / data-valid / preamble-mark line to the sink
//   busy        high outside IDLE
//   frame_cnt   completed frames this session, saturating at 15
//   done        one-cycle pulse at session end
//   err         sticky address-mismatch flag
module scan_frame_tx #(
    parameter int unsigned WAIT_CYC  = 2,
    parameter int unsigned ADDR_INIT = 24
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       stop,
    input  logic [2:0] pre_len,
    input  logic [3:0] num_frames,
    input  logic       fz_L,
    input  logic [4:0] read_a,
    output logic       s,
    output logic       dv,
    output logic       l_in,
    output logic       busy,
    output logic [3:0] frame_cnt,
    output logic       done,
    output logic       err
);

    localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYC - 1);
    localparam logic [4:0] EXP_INIT  = 5'(ADDR_INIT);

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        LOAD,
        MARK,
        RUN,
        TEARDOWN
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [3:0] phase_cnt;
    logic [2:0] pre_len_q;
    logic [3:0] num_frames_q;
    logic [4:0] exp_addr;
    logic       fz_prev;

    logic       frame_done;
    logic       mismatch;
    logic [3:0] frame_cnt_inc;
    logic       s_next;
    logic       dv_next;
    logic       l_in_next;

    always_comb begin
        frame_done    = (state == RUN) && fz_prev && !fz_L;
        mismatch      = (state == RUN) && (read_a != exp_addr);
        frame_cnt_inc = (frame_cnt == 4'hF) ? 4'hF : frame_cnt + 4'd1;
        state_next    = state;

        case (state)
            IDLE: begin
                if (start) state_next = ARM;
            end
            ARM: begin
                if (stop)                        state_next = TEARDOWN;
                else if (phase_cnt == WAIT_LAST) state_next = LOAD;
            end
            LOAD: begin
                if (stop)                               state_next = TEARDOWN;
                else if (phase_cnt == {1'b0, pre_len_q}) state_next = MARK;
            end
            MARK: begin
                state_next = stop ? TEARDOWN : RUN;
            end
            RUN: begin
                if (stop || mismatch ||
                    (frame_done && num_frames_q != 4'd0 &&
                     frame_cnt_inc == num_frames_q))
                    state_next = TEARDOWN;
            end
            TEARDOWN: state_next = IDLE;
            default:  state_next = IDLE;
        endcase

        // Outputs are decoded from the next state and registered, so they
        // line up with the cycle the state is occupied.
        s_next    = (state_next == ARM) || (state_next == LOAD) ||
                    (state_next == MARK) || (state_next == RUN);
        dv_next   = (state_next == LOAD) || (state_next == MARK) ||
                    (state_next == RUN);
        l_in_next = (state_next == LOAD);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            s            <= 1'b0;
            dv           <= 1'b0;
            l_in         <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            frame_cnt    <= '0;
            phase_cnt    <= '0;
            pre_len_q    <= '0;
            num_frames_q <= '0;
            exp_addr     <= EXP_INIT;
            fz_prev      <= 1'b0;
        end else begin
            state   <= state_next;
            s       <= s_next;
            dv      <= dv_next;
            l_in    <= l_in_next;
            busy    <= (state_next != IDLE);
            done    <= (state_next == TEARDOWN);
            fz_prev <= fz_L;

            if ((state_next == state) && ((state == ARM) || (state == LOAD)))
                phase_cnt <= phase_cnt + 4'd1;
            else
                phase_cnt <= '0;

            // Shadow address only runs while staying in RUN; any other
            // next state puts it back at its initial value.
            if ((state == RUN) && (state_next == RUN))
                exp_addr <= exp_addr - 5'd1;
            else
                exp_addr <= EXP_INIT;

            if ((state == IDLE) && start) begin
                pre_len_q    <= pre_len;
                num_frames_q <= num_frames;
                frame_cnt    <= '0;
                err          <= 1'b0;
            end else begin
                if (frame_done) frame_cnt <= frame_cnt_inc;
                if (mismatch)   err       <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_scan_frame_tx.sv
`timescale 1ns/1ps
// tb_scan_frame_tx
//   Directed sessions laid out on an absolute cycle timeline. Expected
//   outputs for every cycle are derived from session phase lengths and the
//   stimulus schedule, then compared against the DUT mid-cycle, together
//   with a set of hand-computed literal values at key cycles.
module tb_scan_frame_tx;

    localparam int N     = 200;
    localparam int WAIT  = 2;
    localparam int AINIT = 24;

    localparam int SIG_S = 0, SIG_DV = 1, SIG_L = 2, SIG_BUSY = 3,
                   SIG_DONE = 4, SIG_CNT = 5, SIG_ERR = 6;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic [2:0] pre_len = '0;
    logic [3:0] num_frames = '0;
    logic       fz_L = 1'b0;
    logic [4:0] read_a = '0;
    logic       s, dv, l_in, busy, done, err;
    logic [3:0] frame_cnt;

    always #5 clock = ~clock;

    scan_frame_tx #(.WAIT_CYC(WAIT), .ADDR_INIT(AINIT)) dut (
        .clock(clock), .reset(reset), .start(start), .stop(stop),
        .pre_len(pre_len), .num_frames(num_frames), .fz_L(fz_L),
        .read_a(read_a), .s(s), .dv(dv), .l_in(l_in), .busy(busy),
        .frame_cnt(frame_cnt), .done(done), .err(err)
    );

    // stimulus schedule
    bit         st_rst[N];
    bit         st_start[N];
    bit         st_stop[N];
    bit         st_fz[N];
    bit         st_bad[N];
    logic [2:0] st_pre[N];
    logic [3:0] st_nf[N];
    logic [4:0] st_addr[N];

    // expected outputs per cycle
    bit e_s[N], e_dv[N], e_l[N], e_busy[N], e_done[N], e_err[N];
    int e_cnt[N];

    typedef struct {int c; int sig; int val;} lit_t;
    lit_t lits[$];

    int checks = 0;
    int errors = 0;
    int cyc    = -1;

    task automatic put(input int c, input bit s_, input bit dv_, input bit l_,
                       input bit b_, input bit d_, input int cnt, input bit er);
        e_s[c] = s_; e_dv[c] = dv_; e_l[c] = l_; e_busy[c] = b_;
        e_done[c] = d_; e_cnt[c] = cnt; e_err[c] = er;
    endtask

    task automatic idle_from(input int c0, input int cnt, input bit er);
        for (int c = c0; c < N; c++) put(c, 0, 0, 0, 0, 0, cnt, er);
    endtask

    task automatic fz_high(input int lo, input int hi);
        for (int c = lo; c <= hi; c++) st_fz[c] = 1'b1;
    endtask

    task automatic lit(input int c, input int sig, input int val);
        lits.push_back('{c, sig, val});
    endtask

    function automatic logic [4:0] sink_addr(input int k);
        return 5'(((AINIT - k) % 32 + 32) % 32);
    endfunction

    // Session from a start request in cycle t0: phase boundaries follow
    // from WAIT, pre and the stop/reset/bad/fz schedule.
    task automatic plan_session(input int t0, input int pre, input int nf);
        int  arm0, load0, mark0, run0, cnt, end_c;
        bit  er, by_reset, term;
        arm0  = t0 + 1;
        load0 = arm0 + WAIT;
        mark0 = load0 + pre + 1;
        run0  = mark0 + 1;
        st_start[t0] = 1'b1;
        st_pre[t0]   = 3'(pre);
        st_nf[t0]    = 4'(nf);
        for (int c = run0; c < N; c++) begin
            st_addr[c] = sink_addr(c - run0);
            if (st_bad[c]) st_addr[c] = (sink_addr(c - run0) == 5'd5) ? 5'd6 : 5'd5;
        end
        cnt = 0; er = 0; by_reset = 0; end_c = N - 1;
        for (int c = arm0; c < N; c++) begin
            put(c, 1, c >= load0, (c >= load0) && (c < mark0), 1, 0, cnt, er);
            if (st_rst[c]) begin by_reset = 1; end_c = c; break; end
            if (st_stop[c]) begin end_c = c; break; end
            term = 0;
            if (c >= run0) begin
                if (st_bad[c]) begin er = 1; term = 1; end
                if (st_fz[c-1] && !st_fz[c]) begin
                    cnt = (cnt < 15) ? cnt + 1 : 15;
                    if (nf != 0 && cnt == nf) term = 1;
                end
            end
            if (term) begin end_c = c; break; end
        end
        if (by_reset) begin
            idle_from(end_c + 1, 0, 0);
        end else if (end_c + 1 < N) begin
            put(end_c + 1, 0, 0, 0, 1, 1, cnt, er);
            idle_from(end_c + 2, cnt, er);
        end
    endtask

    function automatic string sig_name(input int i);
        case (i)
            SIG_S:    return "s";
            SIG_DV:   return "dv";
            SIG_L:    return "l_in";
            SIG_BUSY: return "busy";
            SIG_DONE: return "done";
            SIG_CNT:  return "frame_cnt";
            default:  return "err";
        endcase
    endfunction

    function automatic logic [3:0] sig_val(input int i);
        case (i)
            SIG_S:    return {3'b0, s};
            SIG_DV:   return {3'b0, dv};
            SIG_L:    return {3'b0, l_in};
            SIG_BUSY: return {3'b0, busy};
            SIG_DONE: return {3'b0, done};
            SIG_CNT:  return frame_cnt;
            default:  return {3'b0, err};
        endcase
    endfunction

    task automatic chk(input string name, input int c, input logic [3:0] got,
                       input logic [3:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0d, want %0d", name, c, got, want);
        end
    endtask

    always @(negedge clock) begin
        if (cyc >= 0) begin
            chk("s",         cyc, {3'b0, s},    {3'b0, e_s[cyc]});
            chk("dv",        cyc, {3'b0, dv},   {3'b0, e_dv[cyc]});
            chk("l_in",      cyc, {3'b0, l_in}, {3'b0, e_l[cyc]});
            chk("busy",      cyc, {3'b0, busy}, {3'b0, e_busy[cyc]});
            chk("done",      cyc, {3'b0, done}, {3'b0, e_done[cyc]});
            chk("frame_cnt", cyc, frame_cnt,    4'(e_cnt[cyc]));
            chk("err",       cyc, {3'b0, err},  {3'b0, e_err[cyc]});
            foreach (lits[i])
                if (lits[i].c == cyc)
                    chk({"lit_", sig_name(lits[i].sig)}, cyc,
                        sig_val(lits[i].sig), 4'(lits[i].val));
        end
    end

    initial begin
        for (int c = 0; c < N; c++) begin
            st_pre[c] = '0; st_nf[c] = '0; st_addr[c] = '0;
        end
        st_rst[0] = 1'b1;
        st_rst[1] = 1'b1;

        // A: pre_len=1, one frame; starts during RUN and TEARDOWN ignored
        fz_high(11, 34);
        st_start[20] = 1'b1;
        plan_session(4, 1, 1);
        st_start[36] = 1'b1;
        // B: address mismatch where shadow address is 20
        st_bad[54] = 1'b1;
        plan_session(45, 0, 0);
        // C: unlimited, three frames across the 0->31 wrap, then stop
        fz_high(80, 84); fz_high(90, 94); fz_high(100, 104);
        st_stop[110] = 1'b1;
        plan_session(70, 2, 0);
        // D: longest preamble, reset held two cycles mid-RUN
        fz_high(134, 137);
        st_rst[145] = 1'b1; st_rst[146] = 1'b1;
        plan_session(120, 7, 3);
        // E: stop in ARM; later stop in IDLE has no effect
        st_stop[156] = 1'b1; st_stop[165] = 1'b1;
        plan_session(155, 3, 2);
        // F: frame limit reached in the same cycle as a mismatch
        fz_high(176, 178); fz_high(181, 182);
        st_bad[183] = 1'b1;
        plan_session(170, 0, 2);

        lit(0, SIG_BUSY, 0); lit(2, SIG_CNT, 0);
        lit(5, SIG_S, 1); lit(5, SIG_DV, 0); lit(6, SIG_DV, 0);
        lit(7, SIG_L, 1); lit(8, SIG_L, 1); lit(9, SIG_L, 0); lit(9, SIG_DV, 1);
        lit(10, SIG_DV, 1); lit(36, SIG_DONE, 1); lit(36, SIG_CNT, 1);
        lit(37, SIG_BUSY, 0); lit(37, SIG_ERR, 0); lit(37, SIG_DONE, 0);
        lit(48, SIG_L, 1); lit(49, SIG_L, 0); lit(55, SIG_ERR, 1);
        lit(55, SIG_DONE, 1); lit(56, SIG_BUSY, 0); lit(70, SIG_ERR, 1);
        lit(71, SIG_ERR, 0);
        lit(75, SIG_L, 1); lit(76, SIG_L, 0); lit(85, SIG_CNT, 0);
        lit(86, SIG_CNT, 1); lit(96, SIG_CNT, 2); lit(106, SIG_CNT, 3);
        lit(110, SIG_DONE, 0); lit(111, SIG_DONE, 1); lit(112, SIG_DONE, 0);
        lit(115, SIG_CNT, 3);
        lit(122, SIG_L, 0); lit(123, SIG_L, 1); lit(130, SIG_L, 1);
        lit(131, SIG_L, 0); lit(139, SIG_CNT, 1); lit(146, SIG_BUSY, 0);
        lit(147, SIG_CNT, 0); lit(147, SIG_S, 0);
        lit(156, SIG_S, 1); lit(157, SIG_L, 0); lit(157, SIG_DV, 0);
        lit(157, SIG_DONE, 1); lit(157, SIG_CNT, 0); lit(158, SIG_BUSY, 0);
        lit(184, SIG_CNT, 2); lit(184, SIG_ERR, 1); lit(184, SIG_DONE, 1);
        lit(185, SIG_BUSY, 0);

        for (int c = 0; c < N; c++) begin
            @(posedge clock);
            #1;
            cyc        = c;
            reset      = st_rst[c];
            start      = st_start[c];
            stop       = st_stop[c];
            pre_len    = st_pre[c];
            num_frames = st_nf[c];
            fz_L       = st_fz[c];
            read_a     = st_addr[c];
        end
        @(negedge clock);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
